// File: rtl/ddr_read_fifo.sv
`default_nettype none
// ============================================================================
// ddr_read_fifo : single-clock first-word-fall-through FIFO with prog_full
// Revision 1.0
// ============================================================================
module ddr_read_fifo #(
    parameter int ADDR_WIDTH       = 3,
    parameter int DATA_WIDTH       = 1,
    parameter int PROG_FULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  prog_full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_THRESH = PROG_FULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt;

    assign empty     = (count_q == '0);
    assign full      = (count_q == C_DEPTH);
    assign prog_full = (count_q >= C_THRESH);
    assign count     = count_q;
    assign dout      = dout_q;

    assign wr_acc     = wr_en && !full;
    assign rd_acc     = rd_en && !empty;
    assign rd_ptr_nxt = rd_ptr_q + C_PTR_ONE;

    // dout is a register so the head word is stable, reset to zero, and held on underflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_nxt;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase

        if (empty) begin
            if (wr_acc) begin
                dout_d = din;
            end
        end else if (rd_acc) begin
            // Next head is already in memory unless the popped word was the last one
            if (count_q > C_ONE) begin
                dout_d = mem_q[rd_ptr_nxt];
            end else if (wr_acc) begin
                dout_d = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !srst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_read_fifo.sv
`default_nettype none
// ============================================================================
// tb_ddr_read_fifo : randomized/directed bench against a queue reference model
// Revision 1.0
// ============================================================================
module tb_ddr_read_fifo;

    logic       clk = 1'b0;
    logic       srst;
    logic       wr_en, rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full, empty, prog_full;
    logic [3:0] count;

    logic       t_wr, t_rd, t_din, t_dout;
    logic       t_full, t_empty, t_prog_full;
    logic [3:0] t_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] wrote[$];
    logic [7:0] popped[$];

    always #5 clk = ~clk;

    ddr_read_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) u_dut (
        .clk(clk), .srst(srst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .prog_full(prog_full), .count(count)
    );

    ddr_read_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(1)) u_tok (
        .clk(clk), .srst(srst), .wr_en(t_wr), .din(t_din), .rd_en(t_rd),
        .dout(t_dout), .full(t_full), .empty(t_empty), .prog_full(t_prog_full), .count(t_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 8));
        chk({tag, ".prog_full"}, 32'(prog_full), 32'(q.size() >= 6));
        if (q.size() > 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
    endtask

    // One clock of stimulus; the model pops before pushing, using pre-edge occupancy.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag);
        bit wacc, racc;
        wr_en = w; din = d; rd_en = r;
        wacc = w && (q.size() < 8);
        racc = r && (q.size() > 0);
        if (racc) begin
            chk({tag, ".pop"}, 32'(dout), 32'(q[0]));
            popped.push_back(dout);
        end
        @(posedge clk); #1;
        if (racc) void'(q.pop_front());
        if (wacc) begin
            q.push_back(d);
            wrote.push_back(d);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check_state(tag);
    endtask

    initial begin
        int sent;
        int guard;
        logic [7:0] d0;
        int wcyc[$];
        logic tdat[$];
        int nreads;
        int pulses;

        srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        t_wr = 1'b0; t_rd = 1'b0; t_din = 1'b0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        chk("reset.dout", 32'(dout), 32'h0);
        check_state("reset");

        cyc(1'b1, 8'hA5, 1'b0, "wr_a5");
        chk("wr_a5.dout_fwft", 32'(dout), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, "rd_a5");

        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, "fill");
        cyc(1'b1, 8'hFF, 1'b0, "overflow");
        chk("overflow.count", 32'(count), 32'd8);
        popped.delete();
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, "drain");
        for (int i = 0; i < 8; i++) chk("drain.order", 32'(popped[i]), 32'(i));
        chk("drain.empty", 32'(empty), 32'd1);

        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, "pre4");
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b1, "simul4");
        chk("simul4.count", 32'(count), 32'd4);

        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, "tofull");
        cyc(1'b1, 8'hEE, 1'b1, "simul_full");
        chk("simul_full.count", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, "drain2");
        cyc(1'b1, 8'h33, 1'b1, "simul_empty");
        chk("simul_empty.count", 32'(count), 32'd1);
        chk("simul_empty.dout", 32'(dout), 32'h33);
        cyc(1'b0, 8'h00, 1'b1, "drain3");

        wrote.delete(); popped.delete();
        sent = 0; guard = 0;
        while ((sent < 20 || q.size() > 0) && guard < 500) begin
            logic w, r;
            w = (sent < 20) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (w && q.size() < 8) sent++;
            cyc(w, 8'($urandom), r, "stream");
            guard++;
        end
        chk("stream.timeout", 32'(guard < 500), 32'd1);
        chk("stream.npop", 32'(popped.size()), 32'(wrote.size()));
        for (int i = 0; i < wrote.size() && i < popped.size(); i++)
            chk("stream.data", 32'(popped[i]), 32'(wrote[i]));

        d0 = dout;
        cyc(1'b0, 8'h00, 1'b1, "underflow");
        chk("underflow.dout", 32'(dout), 32'(d0));
        cyc(1'b1, 8'h5C, 1'b0, "post_underflow");
        chk("post_underflow.dout", 32'(dout), 32'h5C);

        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, "to5");
        chk("to5.count", 32'(count), 32'd5);
        srst = 1'b1; wr_en = 1'b1; din = 8'h77;
        @(posedge clk); #1;
        srst = 1'b0; wr_en = 1'b0;
        q.delete();
        chk("midrst.dout", 32'(dout), 32'h0);
        check_state("midrst");

        // Token channel: consumer pops whenever not empty
        nreads = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            t_wr  = (c >= 2) && (pulses < 5) && (($urandom_range(0, 2) == 0) || c >= 20);
            t_din = 1'($urandom_range(0, 1));
            t_rd  = !t_empty;
            if (t_rd) begin
                nreads++;
                chk("tok.pending", 32'(wcyc.size() > 0), 32'd1);
                if (wcyc.size() > 0) begin
                    chk("tok.latency", 32'(c), 32'(wcyc[0] + 1));
                    chk("tok.data", 32'(t_dout), 32'(tdat[0]));
                    void'(wcyc.pop_front());
                    void'(tdat.pop_front());
                end
            end
            if (t_wr) begin
                pulses++;
                wcyc.push_back(c);
                tdat.push_back(t_din);
            end
            @(posedge clk); #1;
        end
        t_wr = 1'b0; t_rd = 1'b0;
        chk("tok.reads", 32'(nreads), 32'd5);
        chk("tok.empty", 32'(t_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_read_fifo.md
# ddr_read_fifo

Single-clock, first-word-fall-through (FWFT) FIFO with a programmable almost-full flag. It is the queueing element of the DDR3 DMA read path. It carries read-address/burst-length descriptors toward the AXI AR channel, read data beats toward the DMA consumer, and 1-bit completion tokens for read-credit accounting. Clock-domain crossing is out of scope: producer and consumer share `clk`.

## Interface
Parameters, in positional order:
- `ADDR_WIDTH`, default 3: log2 of the depth. Depth is `2**ADDR_WIDTH` entries.
- `DATA_WIDTH`, default 1: word width in bits.
- `PROG_FULL_THRESH`, default `2**ADDR_WIDTH - 2`: occupancy at or above which `prog_full` asserts. Legal range is 1 to depth.

Ports:
- `clk`, input, 1: the only clock. All logic is on the rising edge.
- `srst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: write request.
- `din`, input, DATA_WIDTH: write data.
- `rd_en`, input, 1: read (pop) request.
- `dout`, output, DATA_WIDTH: head-of-queue word. Valid whenever `empty` is 0.
- `full`, output, 1: occupancy equals depth.
- `empty`, output, 1: occupancy is 0.
- `prog_full`, output, 1: occupancy ≥ `PROG_FULL_THRESH`.
- `count`, output, ADDR_WIDTH+1: current occupancy.

## Operation
- Storage: circular memory of depth `2**ADDR_WIDTH` × DATA_WIDTH, plus a registered write pointer, read pointer and occupancy counter.
- Write acceptance:
  - A write is accepted iff `wr_en` is 1 and `full` is 0.
  - Accepting a write stores `din` at the write pointer and increments the write pointer modulo depth.
- Read acceptance:
  - A read is accepted iff `rd_en` is 1 and `empty` is 0.
  - Accepting a read increments the read pointer modulo depth.
- Rejected operations:
  - A write while full is dropped. Memory, pointers and flags are unchanged.
  - A read while empty is ignored. `dout` is unchanged.
- FWFT behaviour:
  - `dout` always presents the oldest unread word, with no read request needed.
  - `rd_en` pops that word. The consumer samples `dout` in the same cycle it asserts `rd_en`.
- Occupancy update per cycle:
  - `count` rises by 1 for an accepted write alone.
  - `count` falls by 1 for an accepted read alone.
  - `count` is unchanged when both are accepted or neither is.
- Flags are decoded from the registered `count`:
  - `empty` = (`count` == 0).
  - `full` = (`count` == depth).
  - `prog_full` = (`count` ≥ `PROG_FULL_THRESH`).
- Simultaneous read and write:
  - When full: only the read is accepted. Occupancy becomes depth−1 and `full` drops next cycle.
  - When empty: only the write is accepted. The word appears next cycle.
  - Otherwise: both are accepted and `count` holds.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap naturally. Full/empty are decided from `count`, never from pointer equality.

## Timing
- Reset (`srst` = 1 at a rising edge):
  - Pointers become 0 and `count` becomes 0.
  - `empty` = 1, `full` = 0, `prog_full` = 0, `dout` = 0.
  - Memory contents are not cleared.
  - `srst` overrides `wr_en`/`rd_en` in the same cycle. Data in flight at reset is discarded.
- Write-to-read latency: a word written into an empty FIFO at edge N is visible on `dout`, with `empty` = 0, after edge N. The consumer can pop it in cycle N+1.
- Read-to-next-word latency: after a pop at edge N, `dout` shows the next word right after edge N, if one exists. Otherwise `empty` = 1 after edge N.
- Back-to-back throughput: one write and one read per cycle sustained, with no bubbles.
- Flag timing: all flags and `count` are registered. Each reflects the operations accepted at the previous edge.
- `prog_full` timing:
  - It asserts the cycle after the write that reaches the threshold.
  - Producers that gate `wr_en` with `prog_full` still have `depth − PROG_FULL_THRESH` entries of slack.

## Test plan
- Reset and basic FWFT:
  - Reset with ADDR_WIDTH=3, DATA_WIDTH=8 → `empty`=1, `full`=0, `prog_full`=0, `count`=0, `dout`=0.
  - Write 0xA5 → next cycle `empty`=0, `dout`=0xA5, `count`=1.
- Fill to full: write 0..7 on 8 consecutive cycles.
  - `prog_full` rises after the 6th write (thresh 6).
  - `full` rises after the 8th write.
  - A 9th write of 0xFF is dropped, `count` stays 8.
  - Drain reads back 0..7 in order, then `empty`=1.
- Simultaneous operations:
  - With `count`=4, assert `rd_en` and `wr_en` together for 10 cycles → `count` stays 4 and data order is preserved.
  - At full, read and write together → only the read is accepted, `count`=7.
  - At empty, read and write together → only the write is accepted, `count`=1.
- Wrap-around: stream 20 words with a random mix of read/write stalls → read sequence equals write sequence; no flag violations; `count` never exceeds 8.
- Underflow and reset mid-operation:
  - `rd_en` while empty → `dout`, `count` and pointers are unchanged.
  - Assert `srst` with `count`=5 and `wr_en`=1 → next cycle `count`=0, `empty`=1, `dout`=0.
- 1-bit token configuration (ADDR_WIDTH=3, DATA_WIDTH=1):
  - Producer pulses `wr_en` 5 times while the consumer pops on `~empty` each cycle.
  - Exactly 5 reads occur, each in the cycle after its write.
